// File: rtl/fb_pkg.sv
// Shared screen geometry, colour constants and FSM state types for the plot sink.
// Optional build macro consumed by fb_plot_sink: FB_COLOUR_KEY_EN.
package fb_pkg;
  localparam int SCR_W   = 160;
  localparam int SCR_H   = 120;
  localparam int ADDR_W  = 15;
  localparam int FB_SIZE = SCR_W * SCR_H;

  localparam logic [2:0] BLACK      = 3'b000;
  localparam logic [2:0] WHITE      = 3'b111;
  localparam logic [2:0] RED        = 3'b100;
  localparam logic [2:0] KEY_COLOUR = 3'b010;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);

  typedef enum logic {C_IDLE, C_FILL} clear_state_t;
  typedef enum logic [1:0] {P_IDLE, P_WAIT, P_READ} probe_state_t;
endpackage

// File: rtl/fb_addr_calc.sv
// Combinational (x, y) -> linear frame-buffer address plus on-screen flag.
module fb_addr_calc
  import fb_pkg::*;
(
  input  logic [7:0]        x,
  input  logic [6:0]        y,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);
  logic [ADDR_W-1:0] y_ext;
  logic [ADDR_W-1:0] x_ext;

  assign y_ext = ADDR_W'(y);
  assign x_ext = ADDR_W'(x);

  // y*160 as y*128 + y*32
  assign addr     = (y_ext << 7) + (y_ext << 5) + x_ext;
  assign in_range = (32'(x) < SCR_W) && (32'(y) < SCR_H);
endmodule

// File: rtl/fb_plot_sink.sv
// Plot stream to frame-buffer writer with full-screen clear and a colour-probe read port.
// Build macro FB_COLOUR_KEY_EN: discard in-range plots whose colour equals KEY_COLOUR.
module fb_plot_sink
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              plot,
  input  logic [7:0]        x,
  input  logic [6:0]        y,
  input  logic [2:0]        colour,
  input  logic              clear_req,
  input  logic [2:0]        clear_colour,
  output logic              clear_busy,
  input  logic              probe_req,
  input  logic [7:0]        probe_x,
  input  logic [6:0]        probe_y,
  output logic              probe_busy,
  output logic              probe_valid,
  output logic [2:0]        probe_colour,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_wdata,
  output logic              mem_we,
  input  logic [2:0]        mem_rdata,
  output logic [7:0]        drop_cnt
);
  logic [ADDR_W-1:0] plot_addr;
  logic              plot_ok;
  logic [ADDR_W-1:0] probe_addr;
  logic              probe_ok;
  logic              key_hit;

  clear_state_t      clr_state;
  logic [ADDR_W-1:0] clr_addr;
  logic [2:0]        clr_colour;
  logic              filling;

  logic              wr_vld_p0;
  logic [ADDR_W-1:0] wr_addr_p0;
  logic [2:0]        wr_data_p0;

  probe_state_t      prb_state;
  logic [ADDR_W-1:0] prb_addr;
  logic              prb_oor;
  logic              read_issue;

  fb_addr_calc u_plot_calc (.x(x), .y(y), .addr(plot_addr), .in_range(plot_ok));
  fb_addr_calc u_probe_calc (.x(probe_x), .y(probe_y), .addr(probe_addr), .in_range(probe_ok));

`ifdef FB_COLOUR_KEY_EN
  assign key_hit = (colour == KEY_COLOUR);
`else
  assign key_hit = 1'b0;
`endif

  assign filling    = (clr_state == C_FILL);
  assign read_issue = (prb_state == P_WAIT) && !prb_oor && !filling && !wr_vld_p0;

  // Port arbitration: clear write, then plot write, then probe read
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (filling) begin
      mem_we    = 1'b1;
      mem_addr  = clr_addr;
      mem_wdata = clr_colour;
    end else if (wr_vld_p0) begin
      mem_we    = 1'b1;
      mem_addr  = wr_addr_p0;
      mem_wdata = wr_data_p0;
    end else if (read_issue) begin
      mem_addr  = prb_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_state  <= C_IDLE;
      clr_addr   <= '0;
      clr_colour <= '0;
      clear_busy <= 1'b0;
    end else begin
      case (clr_state)
        C_IDLE: if (clear_req) begin
          clr_state  <= C_FILL;
          clr_addr   <= '0;
          clr_colour <= clear_colour;
          clear_busy <= 1'b1;
        end
        C_FILL: if (clr_addr == LAST_ADDR) begin
          clr_state  <= C_IDLE;
          clear_busy <= 1'b0;
        end else begin
          clr_addr <= clr_addr + 1'b1;
        end
        default: clr_state <= C_IDLE;
      endcase
    end
  end

  // Stage p0: registered plot write; plots during a fill vanish uncounted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_vld_p0 <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      wr_vld_p0 <= plot && plot_ok && !filling && !key_hit;
      if (plot && !plot_ok && !filling && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (plot) begin
      wr_addr_p0 <= plot_addr;
      wr_data_p0 <= colour;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prb_state   <= P_IDLE;
      prb_addr    <= '0;
      prb_oor     <= 1'b0;
      probe_busy  <= 1'b0;
      probe_valid <= 1'b0;
    end else begin
      probe_valid <= 1'b0;
      case (prb_state)
        P_IDLE: if (probe_req) begin
          prb_state  <= P_WAIT;
          prb_addr   <= probe_addr;
          prb_oor    <= !probe_ok;
          probe_busy <= 1'b1;
        end
        P_WAIT: if (prb_oor || read_issue) begin
          prb_state   <= P_READ;
          probe_valid <= 1'b1;
        end
        P_READ: begin
          prb_state  <= P_IDLE;
          probe_busy <= 1'b0;
        end
        default: prb_state <= P_IDLE;
      endcase
    end
  end

  // Read data lands in the P_READ cycle, which is exactly when probe_valid is high
  assign probe_colour = (probe_valid && !prb_oor) ? mem_rdata : 3'b000;
endmodule

// File: tb/tb_fb_plot_sink.sv
// Directed self-checking bench for fb_plot_sink with a behavioural frame-buffer RAM.
module tb_fb_plot_sink;
  import fb_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              plot;
  logic [7:0]        x;
  logic [6:0]        y;
  logic [2:0]        colour;
  logic              clear_req;
  logic [2:0]        clear_colour;
  logic              clear_busy;
  logic              probe_req;
  logic [7:0]        probe_x;
  logic [6:0]        probe_y;
  logic              probe_busy;
  logic              probe_valid;
  logic [2:0]        probe_colour;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_wdata;
  logic              mem_we;
  logic [2:0]        mem_rdata;
  logic [7:0]        drop_cnt;

  logic [2:0] fbm [0:FB_SIZE-1];
  int n_checks = 0;
  int n_fail   = 0;

  fb_plot_sink dut (
    .clk(clk), .reset(reset), .plot(plot), .x(x), .y(y), .colour(colour),
    .clear_req(clear_req), .clear_colour(clear_colour), .clear_busy(clear_busy),
    .probe_req(probe_req), .probe_x(probe_x), .probe_y(probe_y),
    .probe_busy(probe_busy), .probe_valid(probe_valid), .probe_colour(probe_colour),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < FB_SIZE; i++) fbm[i] = 3'd5;
    mem_rdata = 3'd0;
  end

  always @(posedge clk) begin
    if (32'(mem_addr) < FB_SIZE) begin
      mem_rdata <= fbm[mem_addr];
      if (mem_we) fbm[mem_addr] <= mem_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_mem: got we=%0b addr=%0d wdata=%0d, expected all 0", mem_we, mem_addr, mem_wdata);
    end
    n_checks++;
    if ({clear_busy, probe_busy, probe_valid, probe_colour, drop_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got cb=%0b pb=%0b pv=%0b pc=%0d drop=%0d, expected all 0",
               clear_busy, probe_busy, probe_valid, probe_colour, drop_cnt);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_plot_write();
    plot = 1'b1; x = 8'd0; y = 7'd0; colour = 3'b111;
    tick();
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 15'd0 || mem_wdata !== 3'b111) begin
      n_fail++;
      $display("FAIL plot_origin: got we=%0b addr=%0d wdata=%0d, expected we=1 addr=0 wdata=7", mem_we, mem_addr, mem_wdata);
    end
    x = 8'd159; y = 7'd119; colour = 3'b100;
    tick();
    plot = 1'b0;
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 15'd19199 || mem_wdata !== 3'b100) begin
      n_fail++;
      $display("FAIL plot_corner: got we=%0b addr=%0d wdata=%0d, expected we=1 addr=19199 wdata=4", mem_we, mem_addr, mem_wdata);
    end
    tick();
    n_checks++;
    if (mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL plot_idle: got we=%0b, expected 0", mem_we);
    end
  endtask

  task automatic test_drop();
    plot = 1'b1; x = 8'd160; y = 7'd5; colour = 3'b001;
    tick();
    n_checks++;
    if (mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_x: got we=%0b, expected 0", mem_we);
    end
    x = 8'd3; y = 7'd120;
    tick();
    n_checks++;
    if (mem_we !== 1'b0 || drop_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL drop_y: got we=%0b drop=%0d, expected we=0 drop=2", mem_we, drop_cnt);
    end
    x = 8'd200; y = 7'd0;
    repeat (300) tick();
    plot = 1'b0;
    tick();
    n_checks++;
    if (drop_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL drop_saturate: got drop=%0d, expected 255", drop_cnt);
    end
  endtask

  task automatic test_clear();
    int n = 0;
    int bad = 0;
    apply_reset();
    clear_req = 1'b1; clear_colour = 3'b000;
    tick();
    clear_req = 1'b0;
    while (clear_busy === 1'b1 && n < 20000) begin
      if (mem_we !== 1'b1 || mem_addr !== 15'(n) || mem_wdata !== 3'b000) bad++;
      n++;
      if (n == 100) begin plot = 1'b1; x = 8'd1; y = 7'd1; colour = 3'b111; end
      if (n == 101) x = 8'd200;
      if (n == 102) plot = 1'b0;
      tick();
    end
    n_checks++;
    if (n != 19200) begin
      n_fail++;
      $display("FAIL clear_len: got %0d busy cycles, expected 19200", n);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL clear_seq: got %0d bad fill cycles, expected 0", bad);
    end
    n_checks++;
    if (mem_we !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL clear_after: got we=%0b drop=%0d, expected we=0 drop=0", mem_we, drop_cnt);
    end
    n_checks++;
    if (fbm[0] !== 3'd0 || fbm[161] !== 3'd0 || fbm[19199] !== 3'd0) begin
      n_fail++;
      $display("FAIL clear_mem: got [0]=%0d [161]=%0d [19199]=%0d, expected 0", fbm[0], fbm[161], fbm[19199]);
    end
  endtask

  task automatic test_burst_probe();
    int early = 0;
    int busy_seen = 0;
    probe_x = 8'd50; probe_y = 7'd50;
    for (int i = 0; i < 10; i++) begin
      plot = 1'b1; x = 8'd50; y = 7'd50; colour = 3'((i % 7) + 1);
      probe_req = (i == 2);
      tick();
      if (probe_valid !== 1'b0) early++;
      if (i == 4) busy_seen = int'(probe_busy);
    end
    plot = 1'b0;
    n_checks++;
    if (early != 0 || busy_seen != 1) begin
      n_fail++;
      $display("FAIL burst_wait: got early_valid=%0d busy=%0d, expected 0 and 1", early, busy_seen);
    end
    for (int k = 0; k < 20 && probe_valid !== 1'b1; k++) tick();
    n_checks++;
    if (probe_valid !== 1'b1 || probe_colour !== 3'd3) begin
      n_fail++;
      $display("FAIL burst_probe: got valid=%0b colour=%0d, expected valid=1 colour=3", probe_valid, probe_colour);
    end
    tick();
  endtask

  task automatic test_probe_latency();
    probe_req = 1'b1; probe_x = 8'd50; probe_y = 7'd50;
    tick();
    probe_req = 1'b0;
    n_checks++;
    if (probe_valid !== 1'b0 || probe_busy !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 15'd8050) begin
      n_fail++;
      $display("FAIL probe_issue: got valid=%0b busy=%0b we=%0b addr=%0d, expected 0 1 0 8050",
               probe_valid, probe_busy, mem_we, mem_addr);
    end
    tick();
    n_checks++;
    if (probe_valid !== 1'b1 || probe_colour !== 3'd3) begin
      n_fail++;
      $display("FAIL probe_min_lat: got valid=%0b colour=%0d, expected valid=1 colour=3", probe_valid, probe_colour);
    end
    tick();
    n_checks++;
    if (probe_valid !== 1'b0 || probe_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL probe_pulse: got valid=%0b busy=%0b, expected 0 0", probe_valid, probe_busy);
    end
  endtask

  task automatic test_probe_oor();
    probe_req = 1'b1; probe_x = 8'd200; probe_y = 7'd10;
    tick();
    probe_req = 1'b0;
    n_checks++;
    if (probe_valid !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 15'd0) begin
      n_fail++;
      $display("FAIL oor_wait: got valid=%0b we=%0b addr=%0d, expected 0 0 0", probe_valid, mem_we, mem_addr);
    end
    tick();
    n_checks++;
    if (probe_valid !== 1'b1 || probe_colour !== 3'd0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_result: got valid=%0b colour=%0d we=%0b, expected 1 0 0", probe_valid, probe_colour, mem_we);
    end
    tick();
  endtask

  task automatic test_colour_key();
    plot = 1'b1; x = 8'd10; y = 7'd10; colour = 3'b010;
    tick();
    plot = 1'b0;
`ifdef FB_COLOUR_KEY_EN
    n_checks++;
    if (mem_we !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL colour_key: got we=%0b drop=%0d, expected we=0 drop=0", mem_we, drop_cnt);
    end
`else
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 15'd1610 || mem_wdata !== 3'b010) begin
      n_fail++;
      $display("FAIL colour_nokey: got we=%0b addr=%0d wdata=%0d, expected 1 1610 2", mem_we, mem_addr, mem_wdata);
    end
`endif
    tick();
  endtask

  task automatic test_reset_mid_clear();
    int stray = 0;
    clear_req = 1'b1; clear_colour = 3'b111;
    tick();
    clear_req = 1'b0;
    repeat (50) tick();
    n_checks++;
    if (clear_busy !== 1'b1 || mem_addr !== 15'd50) begin
      n_fail++;
      $display("FAIL midclear_run: got busy=%0b addr=%0d, expected 1 50", clear_busy, mem_addr);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (clear_busy !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL midclear_abort: got busy=%0b we=%0b, expected 0 0", clear_busy, mem_we);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_we !== 1'b0 || clear_busy !== 1'b0) stray++;
    end
    n_checks++;
    if (stray != 0 || fbm[100] !== 3'd0) begin
      n_fail++;
      $display("FAIL midclear_quiet: got %0d stray cycles fbm[100]=%0d, expected 0 0", stray, fbm[100]);
    end
  endtask

  initial begin
    reset = 1'b1; plot = 1'b0; x = '0; y = '0; colour = '0;
    clear_req = 1'b0; clear_colour = '0;
    probe_req = 1'b0; probe_x = '0; probe_y = '0;
    test_reset();
    test_plot_write();
    test_drop();
    test_clear();
    test_burst_probe();
    test_probe_latency();
    test_probe_oor();
    test_colour_key();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
